serial_tx_engine: RTL and testbench
===================================

// Module: serial_tx_engine
// PURPOSE
//  Transmit side of the serial block. It pops 9-bit words from the TX FIFO
//  (my9x16-style: edge-detected rd_request, registered rd_data) and serializes
//  each word onto tx as an async frame: start, 5-8 data bits LSB first,
//  optional parity or 9th/address bit, then 1 or 2 stop bits.
//  It sits between the TX FIFO and the pad, and mirrors the receiver framing.
// PARAMETERS
//  DIV_W   16  width of baud_div (clock cycles per bit)
// PORTS
//  clock            in   1      system clock, all logic on posedge
//  reset            in   1      asynchronous, active-high reset
//  enable           in   1      1 = start new frames when FIFO not empty
//  baud_div         in   DIV_W  clock cycles per bit; values <2 treated as 2
//  word_size        in   2      00=5, 01=6, 10=7, 11=8 data bits
//  parity_en        in   1      append parity bit (ignored if nine_bit=1)
//  parity_odd       in   1      1 = odd parity, 0 = even parity
//  nine_bit         in   1      append fifo word bit 8 instead of parity
//  two_stop         in   1      1 = 2 stop bits, 0 = 1 stop bit
//  fifo_empty       in   1      TX FIFO empty flag
//  fifo_rd_data     in   9      TX FIFO read data, valid 1 clk after rd pulse
//  fifo_rd_request  out  1      one-clock pop pulse to TX FIFO
//  tx               out  1      serial line, idles high
//  busy             out  1      1 in every state except IDLE
//  tx_done          out  1      one-clock pulse at end of last stop bit
// BEHAVIOUR
//  Reset (async): state=IDLE, tx=1, busy=0, fifo_rd_request=0, tx_done=0,
//   bit timer=0, shift reg=0. Reset mid-frame forces tx=1 at once (truncated frame).
//  FSM: IDLE -> FETCH -> WAIT -> LOAD -> START -> DATA -> [PAR] -> STOP -> IDLE|FETCH
//   IDLE : if enable && !fifo_empty -> FETCH.
//   FETCH: fifo_rd_request=1 for exactly this cycle -> WAIT.
//   WAIT : 1 cycle for FIFO registered read -> LOAD.
//   LOAD : capture fifo_rd_data, word_size, parity_en, parity_odd, nine_bit,
//          two_stop, baud_div into shadow regs -> START. Later input
//          changes do not affect the frame in flight.
//   START: tx=0 for one bit period.
//   DATA : tx=shift[0], shift right each bit tick. N=word_size+5 bits.
//   PAR  : entered if nine_bit or parity_en. nine_bit: tx=word[8].
//          Otherwise tx = XOR(data bits [N-1:0]) ^ parity_odd.
//   STOP : tx=1 for 1 or 2 bit periods. On the final tick, tx_done=1.
//          Next state is FETCH if enable && !fifo_empty, else IDLE.
//  Bit timer: loads div-1 on START entry and on each bit tick, counts down.
//   A tick occurs when the timer reaches 0, so every bit lasts exactly div clocks.
//  Frame length in clocks = div*(1+N+P+S).
//   P = 1 if parity or 9th bit is sent, else 0. S = number of stop bits.
//  Inter-frame gap: exactly 3 clocks of tx=1 (FETCH, WAIT, LOAD) between the
//   end of a stop bit and the next start bit.
//  enable dropped mid-frame: the current frame completes, then the block idles.
//  fifo_empty is sampled only in IDLE and at the final STOP tick.
//  The block never pulses fifo_rd_request while fifo_empty=1.
//  The tx output is registered, so there are no glitches.
//  Unused fifo_rd_data bits above N are ignored (bit 8 is ignored unless nine_bit=1).
// TESTING
//  1. baud_div=4, 8N1, FIFO holds 0x0A5 -> tx: 0, 1,0,1,0,0,1,0,1, 1.
//     Each bit lasts 4 clks, the frame lasts 40 clks, tx_done pulses once,
//     and rd_request pulses once.
//  2. 7E2, word 0x041 (bits 1000001) -> parity bit=0 and two stop bits are sent.
//     Repeat with parity_odd=1 -> parity bit=1.
//  3. nine_bit=1, word 0x155, word_size=11 -> 8 data bits 0x55, then 9th bit=1.
//     parity_en=1 is ignored.
//  4. Three words queued, enable=1 -> three back-to-back frames.
//     Exactly 3 idle-high clocks separate them, and rd_request pulses 3 times.
//     No pulse occurs after fifo_empty rises.
//  5. Mid-DATA: drop enable and change baud_div 4->8 -> the frame finishes at 4
//     clks/bit, then the block returns to IDLE.
//     Assert reset mid-frame -> tx=1 and busy=0 on the same edge.
//  6. baud_div=0 and baud_div=1 -> bits last 2 clks.
//     fifo_empty=1 with enable=1 -> tx stays 1 and there are no rd pulses.

Source files
------------

// File: rtl/serial_tx_if.sv
// Bundles the configuration, FIFO pop handshake and serial line of the TX engine.
// The engine connects through the slave modport. The master side drives configuration and FIFO data.
interface serial_tx_if #(
    parameter int DIV_W = 16
);
    logic             enable;
    logic [DIV_W-1:0] baud_div;
    logic [1:0]       word_size;
    logic             parity_en;
    logic             parity_odd;
    logic             nine_bit;
    logic             two_stop;
    logic             fifo_empty;
    logic [8:0]       fifo_rd_data;
    logic             fifo_rd_request;
    logic             tx;
    logic             busy;
    logic             tx_done;

    modport slave (
        input  enable, baud_div, word_size, parity_en, parity_odd, nine_bit,
               two_stop, fifo_empty, fifo_rd_data,
        output fifo_rd_request, tx, busy, tx_done
    );

    modport master (
        output enable, baud_div, word_size, parity_en, parity_odd, nine_bit,
               two_stop, fifo_empty, fifo_rd_data,
        input  fifo_rd_request, tx, busy, tx_done
    );
endinterface

// File: rtl/serial_tx_engine.sv
// Pops 9-bit words from the TX FIFO and serializes each one as an async frame:
// start, 5-8 data bits LSB first, optional parity/9th bit, then 1 or 2 stop bits.
module serial_tx_engine #(
    parameter int DIV_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    serial_tx_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] timer_q;
    logic [DIV_W-1:0] div_q;
    logic [7:0]       shift_q;
    logic [2:0]       bitCnt_q;
    logic [2:0]       lastBit_q;
    logic             parBit_q;
    logic             sendPar_q;
    logic             twoStop_q;
    logic             stopCnt_q;
    logic             tx_q;
    logic             busy_q;
    logic             rdReq_q;
    logic             done_q;

    logic [DIV_W-1:0] effDiv_d;
    logic [7:0]       dataMask_d;
    logic [7:0]       maskedData_d;
    logic             parity_d;
    logic             tick;
    logic             inBitState;
    logic             moreWork;

    assign tick       = (timer_q == '0);
    assign inBitState = (state_q == ST_START) || (state_q == ST_DATA) ||
                        (state_q == ST_PAR)   || (state_q == ST_STOP);
    assign moreWork   = bus.enable && !bus.fifo_empty;
    assign effDiv_d   = (bus.baud_div < DIV_W'(2)) ? DIV_W'(2) : bus.baud_div;

    // Data bits above the word size are cleared so they never reach the line or the parity.
    always_comb begin
        dataMask_d = 8'hFF;
        case (bus.word_size)
            2'd0:    dataMask_d = 8'h1F;
            2'd1:    dataMask_d = 8'h3F;
            2'd2:    dataMask_d = 8'h7F;
            default: dataMask_d = 8'hFF;
        endcase
        maskedData_d = bus.fifo_rd_data[7:0] & dataMask_d;
        parity_d     = bus.nine_bit ? bus.fifo_rd_data[8]
                                    : ((^maskedData_d) ^ bus.parity_odd);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            div_q     <= DIV_W'(2);
            shift_q   <= '0;
            bitCnt_q  <= '0;
            lastBit_q <= '0;
            parBit_q  <= 1'b0;
            sendPar_q <= 1'b0;
            twoStop_q <= 1'b0;
            stopCnt_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            rdReq_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rdReq_q <= 1'b0;
            done_q  <= 1'b0;
            if (inBitState && !tick) begin
                timer_q <= timer_q - DIV_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (moreWork) begin
                        state_q <= ST_FETCH;
                        rdReq_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end

                ST_FETCH: state_q <= ST_WAIT;

                ST_WAIT: state_q <= ST_LOAD;

                // Every frame setting is frozen here so input changes mid-frame have no effect.
                ST_LOAD: begin
                    shift_q   <= maskedData_d;
                    lastBit_q <= {1'b0, bus.word_size} + 3'd4;
                    parBit_q  <= parity_d;
                    sendPar_q <= bus.nine_bit || bus.parity_en;
                    twoStop_q <= bus.two_stop;
                    div_q     <= effDiv_d;
                    timer_q   <= effDiv_d - DIV_W'(1);
                    tx_q      <= 1'b0;
                    state_q   <= ST_START;
                end

                ST_START: begin
                    if (tick) begin
                        tx_q     <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                        bitCnt_q <= '0;
                        timer_q  <= div_q - DIV_W'(1);
                        state_q  <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        timer_q <= div_q - DIV_W'(1);
                        if (bitCnt_q == lastBit_q) begin
                            if (sendPar_q) begin
                                tx_q    <= parBit_q;
                                state_q <= ST_PAR;
                            end else begin
                                tx_q      <= 1'b1;
                                stopCnt_q <= 1'b0;
                                state_q   <= ST_STOP;
                            end
                        end else begin
                            tx_q     <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                            bitCnt_q <= bitCnt_q + 3'd1;
                        end
                    end
                end

                ST_PAR: begin
                    if (tick) begin
                        tx_q      <= 1'b1;
                        stopCnt_q <= 1'b0;
                        timer_q   <= div_q - DIV_W'(1);
                        state_q   <= ST_STOP;
                    end
                end

                // The final stop tick chains straight into the next fetch, giving a 3-clock gap.
                ST_STOP: begin
                    tx_q <= 1'b1;
                    if (tick) begin
                        if (stopCnt_q == twoStop_q) begin
                            done_q  <= 1'b1;
                            timer_q <= '0;
                            if (moreWork) begin
                                state_q <= ST_FETCH;
                                rdReq_q <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            stopCnt_q <= 1'b1;
                            timer_q   <= div_q - DIV_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx              = tx_q;
    assign bus.busy            = busy_q;
    assign bus.fifo_rd_request = rdReq_q;
    assign bus.tx_done         = done_q;

endmodule

// File: tb/tb_serial_tx_engine.sv
// Drives serial_tx_engine from a small FIFO model and checks the logged tx waveform
// against frames rebuilt from the framing rules.
module tb_serial_tx_engine;

    localparam int LOGN = 20000;
    localparam int W_RD = 0;
    localparam int W_DONE = 1;
    localparam int W_BUSY = 2;
    localparam int W_TXLOW = 3;

    typedef struct {
        logic [8:0] word;
        int         ws;
        bit         pen;
        bit         podd;
        bit         nine;
        bit         two;
        int         div;
    } frame_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    serial_tx_if #(.DIV_W(16)) bus();
    serial_tx_engine #(.DIV_W(16)) dut (.clock(clock), .reset(reset), .bus(bus));

    // FIFO model: registered read data, one word popped per request pulse.
    logic [8:0] fifoMem [0:255];
    int pushCount = 0;
    int popCount = 0;
    assign bus.fifo_empty = (pushCount == popCount);
    always @(posedge clock) begin
        if (bus.fifo_rd_request === 1'b1 && pushCount != popCount) begin
            bus.fifo_rd_data <= fifoMem[popCount % 256];
            popCount <= popCount + 1;
        end
    end

    // Per-cycle log of the outputs, sampled on the falling edge.
    logic txLog [LOGN];
    logic rdLog [LOGN];
    logic doneLog [LOGN];
    logic busyLog [LOGN];
    int cyc = 0;
    int emptyViol = 0;
    always @(negedge clock) begin
        if (cyc < LOGN) begin
            txLog[cyc]   = bus.tx;
            rdLog[cyc]   = bus.fifo_rd_request;
            doneLog[cyc] = bus.tx_done;
            busyLog[cyc] = bus.busy;
        end
        if (bus.fifo_rd_request === 1'b1 && bus.fifo_empty === 1'b1) emptyViol++;
        cyc++;
    end

    int tests = 0;
    int fails = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic runCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input frame_t f);
        bus.baud_div   = 16'(f.div);
        bus.word_size  = 2'(f.ws);
        bus.parity_en  = f.pen;
        bus.parity_odd = f.podd;
        bus.nine_bit   = f.nine;
        bus.two_stop   = f.two;
    endtask

    task automatic pushWord(input logic [8:0] w);
        fifoMem[pushCount % 256] = w;
        pushCount = pushCount + 1;
    endtask

    function automatic int countLog(input int which, input int from, input int to);
        int n = 0;
        for (int i = from; i <= to; i++) begin
            if (i < 0 || i >= LOGN || i >= cyc) continue;
            case (which)
                W_RD:    if (rdLog[i] === 1'b1) n++;
                W_DONE:  if (doneLog[i] === 1'b1) n++;
                W_BUSY:  if (busyLog[i] === 1'b1) n++;
                default: if (txLog[i] !== 1'b1) n++;
            endcase
        end
        return n;
    endfunction

    function automatic int findStart(input int from);
        for (int i = from; i < cyc && i < LOGN; i++) begin
            if (i >= 0 && txLog[i] === 1'b0) return i;
        end
        return -1;
    endfunction

    // Reference framing: start, N data bits LSB first, optional parity/9th bit, stop bits.
    function automatic int buildBits(input frame_t f, output logic [15:0] bits);
        int n = 0;
        int nData = f.ws + 5;
        int ones = 0;
        bits = '1;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nData; i++) begin
            bits[n] = f.word[i];
            if (f.word[i]) ones++;
            n++;
        end
        if (f.nine) begin
            bits[n] = f.word[8]; n++;
        end else if (f.pen) begin
            bits[n] = 1'((ones % 2) ^ int'(f.podd)); n++;
        end
        bits[n] = 1'b1; n++;
        if (f.two) begin
            bits[n] = 1'b1; n++;
        end
        return n;
    endfunction

    function automatic int effDiv(input frame_t f);
        return (f.div < 2) ? 2 : f.div;
    endfunction

    task automatic checkFrame(input frame_t f, input int s, input string tag, output int e);
        logic [15:0] exp;
        logic [15:0] obs;
        int n;
        int d;
        int err;
        e = -1;
        checkOutput({tag, "_start_found"}, 32'(s >= 0), 32'd1);
        if (s < 0) return;
        n = buildBits(f, exp);
        d = effDiv(f);
        obs = '1;
        err = 0;
        for (int b = 0; b < n; b++) begin
            int mid = s + b * d + d / 2;
            obs[b] = (mid < LOGN) ? txLog[mid] : 1'bx;
            for (int c = 0; c < d; c++) begin
                int idx = s + b * d + c;
                if (idx >= LOGN || idx >= cyc || txLog[idx] !== exp[b]) err++;
            end
        end
        checkOutput({tag, "_bits"}, 32'(obs), 32'(exp));
        checkOutput({tag, "_wave_errs"}, 32'(err), 32'd0);
        e = s + n * d;
        checkOutput({tag, "_done_at_end"}, (e < LOGN) ? 32'(doneLog[e]) : 32'hx, 32'd1);
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput({tag, "_idle_timeout"}, 32'(n >= budget), 32'd0);
    endtask

    task automatic waitTxLow(input int budget, input string tag, output int s);
        int n = 0;
        s = -1;
        while (bus.tx !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput({tag, "_start_timeout"}, 32'(n >= budget), 32'd0);
        if (n < budget) s = cyc - 1;
    endtask

    task automatic runSingle(input frame_t f, input string tag, output int s);
        int mark;
        int e;
        applyStimulus(f);
        mark = cyc;
        pushWord(f.word);
        bus.enable = 1'b1;
        runCycles(2);
        waitIdle(2000, tag);
        bus.enable = 1'b0;
        runCycles(2);
        s = findStart(mark);
        checkFrame(f, s, tag, e);
        checkOutput({tag, "_rd_pulses"}, 32'(countLog(W_RD, mark, cyc - 1)), 32'd1);
        checkOutput({tag, "_done_pulses"}, 32'(countLog(W_DONE, mark, cyc - 1)), 32'd1);
    endtask

    function automatic frame_t randFrame(input int minDiv, input int maxDiv);
        frame_t f;
        f.word = 9'($urandom_range(0, 511));
        f.ws   = int'($urandom_range(0, 3));
        f.pen  = 1'($urandom_range(0, 1));
        f.podd = 1'($urandom_range(0, 1));
        f.nine = 1'($urandom_range(0, 1));
        f.two  = 1'($urandom_range(0, 1));
        f.div  = int'($urandom_range(minDiv, maxDiv));
        return f;
    endfunction

    initial begin
        frame_t f;
        frame_t g;
        int s;
        int e;
        int s2;
        int mark;
        int d;
        logic [8:0] words [3];

        reset = 1'b1;
        bus.enable = 1'b0;
        bus.fifo_rd_data = '0;
        f = '{word: 9'h0, ws: 3, pen: 0, podd: 0, nine: 0, two: 0, div: 4};
        applyStimulus(f);
        runCycles(3);
        checkOutput("reset_tx", 32'(bus.tx), 32'd1);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_rd", 32'(bus.fifo_rd_request), 32'd0);
        checkOutput("reset_done", 32'(bus.tx_done), 32'd0);
        reset = 1'b0;
        runCycles(3);

        // 8N1 at 4 clocks per bit, word 0x0A5.
        f = '{word: 9'h0A5, ws: 3, pen: 0, podd: 0, nine: 0, two: 0, div: 4};
        runSingle(f, "t1", s);
        checkOutput("t1_done_offset", 32'(countLog(W_DONE, s + 40, s + 40)), 32'd1);
        checkOutput("t1_bit2", (s >= 0) ? 32'(txLog[s + 2 * 4 + 1]) : 32'hx, 32'd0);

        // 7E2 / 7O2 with word 0x041: parity bit sits after 1 start + 7 data bits.
        f = '{word: 9'h041, ws: 2, pen: 1, podd: 0, nine: 0, two: 1, div: 3};
        runSingle(f, "t2e", s);
        checkOutput("t2e_par", (s >= 0) ? 32'(txLog[s + 8 * 3 + 1]) : 32'hx, 32'd0);
        f.podd = 1;
        runSingle(f, "t2o", s);
        checkOutput("t2o_par", (s >= 0) ? 32'(txLog[s + 8 * 3 + 1]) : 32'hx, 32'd1);

        // Nine-bit mode overrides parity_en.
        f = '{word: 9'h155, ws: 3, pen: 1, podd: 0, nine: 1, two: 0, div: 3};
        runSingle(f, "t3", s);
        checkOutput("t3_ninth", (s >= 0) ? 32'(txLog[s + 9 * 3 + 1]) : 32'hx, 32'd1);

        // Three queued words, back-to-back frames with a 3-clock gap.
        f = randFrame(2, 5);
        applyStimulus(f);
        mark = cyc;
        for (int k = 0; k < 3; k++) begin
            words[k] = 9'($urandom_range(0, 511));
            pushWord(words[k]);
        end
        bus.enable = 1'b1;
        runCycles(2);
        waitIdle(3000, "t4");
        bus.enable = 1'b0;
        runCycles(2);
        s = findStart(mark);
        for (int k = 0; k < 3; k++) begin
            g = f;
            g.word = words[k];
            checkFrame(g, s, $sformatf("t4_f%0d", k), e);
            if (k < 2) begin
                s2 = (e >= 0) ? findStart(e) : -1;
                checkOutput($sformatf("t4_gap%0d", k), 32'(s2 - e), 32'd3);
                s = s2;
            end
        end
        checkOutput("t4_rd_pulses", 32'(countLog(W_RD, mark, cyc - 1)), 32'd3);
        checkOutput("t4_done_pulses", 32'(countLog(W_DONE, mark, cyc - 1)), 32'd3);

        // Drop enable and change baud_div mid-DATA: the frame completes at the old rate.
        f = '{word: 9'h0C3, ws: 3, pen: 0, podd: 0, nine: 0, two: 0, div: 4};
        applyStimulus(f);
        mark = cyc;
        pushWord(f.word);
        bus.enable = 1'b1;
        waitTxLow(50, "t5", s);
        runCycles(12);
        bus.enable = 1'b0;
        bus.baud_div = 16'd8;
        pushWord(9'h1FF);
        waitIdle(300, "t5");
        checkFrame(f, s, "t5", e);
        mark = cyc;
        runCycles(30);
        checkOutput("t5_idle_busy", 32'(countLog(W_BUSY, mark, cyc - 1)), 32'd0);
        checkOutput("t5_idle_rd", 32'(countLog(W_RD, mark, cyc - 1)), 32'd0);

        // Reset in the middle of a frame returns the line high immediately.
        bus.enable = 1'b1;
        waitTxLow(50, "t5r", s);
        runCycles(6);
        #1 reset = 1'b1;
        #1;
        checkOutput("t5r_tx", 32'(bus.tx), 32'd1);
        checkOutput("t5r_busy", 32'(bus.busy), 32'd0);
        bus.enable = 1'b0;
        tick();
        reset = 1'b0;
        runCycles(3);

        // Divisors below 2 behave as 2.
        f = '{word: 9'h03C, ws: 3, pen: 1, podd: 1, nine: 0, two: 0, div: 0};
        runSingle(f, "t6d0", s);
        f = '{word: 9'h012, ws: 0, pen: 0, podd: 0, nine: 0, two: 1, div: 1};
        runSingle(f, "t6d1", s);

        // Enable with an empty FIFO does nothing.
        bus.enable = 1'b1;
        mark = cyc;
        runCycles(40);
        bus.enable = 1'b0;
        checkOutput("t6_empty_rd", 32'(countLog(W_RD, mark, cyc - 1)), 32'd0);
        checkOutput("t6_empty_txlow", 32'(countLog(W_TXLOW, mark, cyc - 1)), 32'd0);
        checkOutput("t6_empty_busy", 32'(countLog(W_BUSY, mark, cyc - 1)), 32'd0);

        // Random single frames.
        for (int k = 0; k < 6; k++) begin
            f = randFrame(0, 6);
            runSingle(f, $sformatf("rnd%0d", k), s);
            d = effDiv(f);
            if (s >= 0) begin
                logic [15:0] bits;
                int n;
                n = buildBits(f, bits);
                checkOutput($sformatf("rnd%0d_len", k), 32'(countLog(W_DONE, s + n * d, s + n * d)), 32'd1);
            end
        end

        checkOutput("rd_while_empty", 32'(emptyViol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
